// File: rtl/if_stage_pc.sv
// if_stage_pc: MIPS fetch stage holding the PC, next-PC select and the IF/ID register with stall and flush
module if_stage_pc #(
  parameter int PC_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   jr_control,
  input  logic [PC_WIDTH-1:0]    jr_target,
  input  logic                   jump,
  input  logic [25:0]            jump_index,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_pc4,
  output logic                   ifid_valid,
  output logic                   redirect
);
  logic [PC_WIDTH-1:0] pc, pc4, target;
  assign pc4 = pc + PC_WIDTH'(4);
  assign imem_addr = pc;
  assign redirect = ifid_valid & ~stall & (jr_control | jump | branch_taken);
  // jump region comes from the ID instruction's PC+4, not the fetch PC
  assign target = jr_control ? {jr_target[PC_WIDTH-1:2], 2'b00} :
                  jump       ? {ifid_pc4[PC_WIDTH-1 -: 4], jump_index, 2'b00} :
                               branch_target;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      ifid_instr <= '0;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      pc         <= redirect ? target : pc4;
      ifid_instr <= redirect ? '0 : imem_rdata;
      ifid_pc4   <= redirect ? '0 : pc4;
      ifid_valid <= ~redirect;
    end
  end
endmodule

// File: tb/tb_if_stage_pc.sv
// tb_if_stage_pc: directed scoreboard bench for the fetch stage
module tb_if_stage_pc;
  logic        clk = 1'b0;
  logic        reset_n, stall, jr_control, jump, branch_taken;
  logic [31:0] jr_target, branch_target, imem_addr, imem_rdata, ifid_instr, ifid_pc4;
  logic [25:0] jump_index;
  logic        ifid_valid, redirect;
  int          n_cmp = 0, n_err = 0;

  localparam int K_ADDR = 0, K_INSTR = 1, K_PC4 = 2, K_VALID = 3, K_RED = 4;
  typedef struct {string tag; int kind; logic [31:0] val;} exp_t;
  exp_t sb[$];

  if_stage_pc dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .jr_control(jr_control),
    .jr_target(jr_target), .jump(jump), .jump_index(jump_index),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .redirect(redirect)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr | 32'hA000_0000;

  task automatic push(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.kind = kind;
    e.val = v;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] obs(input int kind);
    case (kind)
      K_ADDR:  return imem_addr;
      K_INSTR: return ifid_instr;
      K_PC4:   return ifid_pc4;
      K_VALID: return {31'd0, ifid_valid};
      default: return {31'd0, redirect};
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.kind);
      n_cmp++;
      assert (o === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ifid(input string tag, input logic [31:0] a, input logic [31:0] ins,
                          input logic [31:0] p4, input logic v);
    push({tag, ".addr"}, K_ADDR, a);
    push({tag, ".instr"}, K_INSTR, ins);
    push({tag, ".pc4"}, K_PC4, p4);
    push({tag, ".valid"}, K_VALID, {31'd0, v});
    drain();
  endtask

  task automatic exp_red(input string tag, input logic r);
    #1;
    push(tag, K_RED, {31'd0, r});
    drain();
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; jr_control = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jr_target = '0; branch_target = '0; jump_index = '0;
    #2;
    exp_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    exp_red("reset.redirect", 1'b0);
    #8 reset_n = 1'b1;
    #1 exp_ifid("fetch0", 32'h0, 32'h0, 32'h0, 1'b0);
    tick(); exp_ifid("fetch1", 32'h4, 32'hA000_0000, 32'h4, 1'b1);
    tick(); exp_ifid("fetch2", 32'h8, 32'hA000_0004, 32'h8, 1'b1);
    stall = 1'b1;
    exp_red("stall.redirect", 1'b0);
    tick(); exp_ifid("stall1", 32'h8, 32'hA000_0004, 32'h8, 1'b1);
    tick(); exp_ifid("stall2", 32'h8, 32'hA000_0004, 32'h8, 1'b1);
    stall = 1'b0;
    tick(); exp_ifid("fetch3", 32'hC, 32'hA000_0008, 32'hC, 1'b1);
    jr_control = 1'b1; jr_target = 32'h0040_0103;
    exp_red("jr.redirect", 1'b1);
    tick(); exp_ifid("jr.flush", 32'h0040_0100, 32'h0, 32'h0, 1'b0);
    exp_red("jr.bubble_redirect", 1'b0);
    jr_control = 1'b0;
    tick(); exp_ifid("jr.target", 32'h0040_0104, 32'hA040_0100, 32'h0040_0104, 1'b1);
    branch_taken = 1'b1; branch_target = 32'h1000_000C;
    exp_red("br.redirect", 1'b1);
    tick(); exp_ifid("br.flush", 32'h1000_000C, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    tick(); exp_ifid("br.target", 32'h1000_0010, 32'hB000_000C, 32'h1000_0010, 1'b1);
    jump = 1'b1; jump_index = 26'h0000040;
    exp_red("j.redirect", 1'b1);
    tick(); exp_ifid("j.flush", 32'h1000_0100, 32'h0, 32'h0, 1'b0);
    jump = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h80;
    exp_red("bubble.redirect", 1'b0);
    tick(); exp_ifid("bubble.seq", 32'h1000_0104, 32'hB000_0100, 32'h1000_0104, 1'b1);
    stall = 1'b1;
    exp_red("stallbr.redirect", 1'b0);
    tick(); exp_ifid("stallbr.hold", 32'h1000_0104, 32'hB000_0100, 32'h1000_0104, 1'b1);
    stall = 1'b0;
    jr_control = 1'b1; jr_target = 32'h200; jump = 1'b1; jump_index = 26'h3FF; branch_target = 32'h80;
    exp_red("prio.redirect", 1'b1);
    tick(); exp_ifid("prio.flush", 32'h200, 32'h0, 32'h0, 1'b0);
    jr_control = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    tick(); exp_ifid("prio.target", 32'h204, 32'hA000_0200, 32'h204, 1'b1);
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    exp_red("wrap.redirect", 1'b1);
    tick(); exp_ifid("wrap.flush", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    tick(); exp_ifid("wrap.zero", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);
    tick(); exp_ifid("wrap.next", 32'h4, 32'hA000_0000, 32'h4, 1'b1);
    #2 reset_n = 1'b0;
    #1 exp_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    exp_red("async_rst.redirect", 1'b0);
    #1 reset_n = 1'b1;
    tick(); exp_ifid("post_rst", 32'h4, 32'hA000_0000, 32'h4, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
